// File: rtl/cpu_pkg.sv
// Shared CPU back-end types: tag/ROB widths, op encodings and the
// reservation-station entry layout used by the issue queue.
package cpu_pkg;

    localparam int PTAG_W = 6;
    localparam int ROB_W  = 4;

    // ALU operation encodings carried through the queue untouched
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } aluop_e;

    // Functional-unit classes carried through the queue untouched
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_MEM = 2'd2,
        FU_BR  = 2'd3
    } fu_e;

    // One reservation-station slot: tags plus per-source ready bits
    typedef struct packed {
        logic              valid;
        logic [PTAG_W-1:0] sr1_p;
        logic              s1_rdy;
        logic [PTAG_W-1:0] sr2_p;
        logic              s2_rdy;
        logic [PTAG_W-1:0] dr_p;
        logic [1:0]        aluop;
        logic [31:0]       imm;
        logic [1:0]        fu;
        logic [ROB_W-1:0]  rob;
    } rs_entry_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: one-hot grant plus a found flag.
module prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         found
);

    // Scan upward; the first set request wins
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Issue queue / reservation station: buffers renamed ops, wakes sources on
// CDB broadcasts, and issues the lowest-index ready op each cycle.
module issue_queue
    import cpu_pkg::*;
#(
    parameter int RS_DEPTH = 16,
    localparam int CNT_W   = $clog2(RS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [PTAG_W-1:0] disp_sr1_p,
    input  logic              disp_s1_ready,
    input  logic [PTAG_W-1:0] disp_sr2_p,
    input  logic              disp_s2_ready,
    input  logic [PTAG_W-1:0] disp_dr_p,
    input  logic [1:0]        disp_aluop,
    input  logic [31:0]       disp_imm,
    input  logic [1:0]        disp_fu,
    input  logic [ROB_W-1:0]  disp_rob,
    input  logic              cdb_valid,
    input  logic [PTAG_W-1:0] cdb_tag,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [PTAG_W-1:0] iss_sr1_p,
    output logic [PTAG_W-1:0] iss_sr2_p,
    output logic [PTAG_W-1:0] iss_dr_p,
    output logic [1:0]        iss_aluop,
    output logic [31:0]       iss_imm,
    output logic [1:0]        iss_fu,
    output logic [ROB_W-1:0]  iss_rob,
    output logic [CNT_W-1:0]  count
);

    rs_entry_t            q [RS_DEPTH];
    logic [RS_DEPTH-1:0] free_req, free_oh;
    logic [RS_DEPTH-1:0] rdy_req, iss_oh;
    logic                free_found, iss_found;
    logic                disp_fire, iss_fire;
    logic                byp_s1, byp_s2;

    // Request vectors come from registered state only, so a slot freed this
    // cycle is never reused by a same-cycle dispatch.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_req[i] = !q[i].valid;
            rdy_req[i]  = q[i].valid && q[i].s1_rdy && q[i].s2_rdy;
        end
    end

    prio_enc #(.N(RS_DEPTH)) u_free_sel (
        .req   (free_req),
        .grant (free_oh),
        .found (free_found)
    );

    prio_enc #(.N(RS_DEPTH)) u_iss_sel (
        .req   (rdy_req),
        .grant (iss_oh),
        .found (iss_found)
    );

    assign disp_ready = (count < CNT_W'(RS_DEPTH)) && !flush;
    assign iss_valid  = iss_found && !flush;
    assign disp_fire  = disp_valid && disp_ready && free_found;
    assign iss_fire   = iss_valid && iss_ready;

    // A source whose tag is on the CDB this cycle is captured as ready
    assign byp_s1 = disp_s1_ready || (cdb_valid && (cdb_tag == disp_sr1_p));
    assign byp_s2 = disp_s2_ready || (cdb_valid && (cdb_tag == disp_sr2_p));

    // Drive the selected entry's fields, zero when nothing issues
    always_comb begin
        iss_sr1_p = '0;
        iss_sr2_p = '0;
        iss_dr_p  = '0;
        iss_aluop = '0;
        iss_imm   = '0;
        iss_fu    = '0;
        iss_rob   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (iss_oh[i] && !flush) begin
                iss_sr1_p = q[i].sr1_p;
                iss_sr2_p = q[i].sr2_p;
                iss_dr_p  = q[i].dr_p;
                iss_aluop = q[i].aluop;
                iss_imm   = q[i].imm;
                iss_fu    = q[i].fu;
                iss_rob   = q[i].rob;
            end
        end
    end

    // Entry storage: wakeup, issue-free and dispatch-write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the whole array is cleared, not just valid bits, so iss_* and debug views start at a known 0.
            for (int i = 0; i < RS_DEPTH; i++) q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) q[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                // NOTE: non-blocking writes; a later write to the same slot in this loop overrides an earlier one.
                if (q[i].valid && cdb_valid && (cdb_tag == q[i].sr1_p)) q[i].s1_rdy <= 1'b1;
                if (q[i].valid && cdb_valid && (cdb_tag == q[i].sr2_p)) q[i].s2_rdy <= 1'b1;
                if (iss_fire && iss_oh[i]) q[i].valid <= 1'b0;
                if (disp_fire && free_oh[i]) begin
                    q[i] <= '{valid: 1'b1, sr1_p: disp_sr1_p, s1_rdy: byp_s1,
                              sr2_p: disp_sr2_p, s2_rdy: byp_s2, dr_p: disp_dr_p,
                              aluop: disp_aluop, imm: disp_imm, fu: disp_fu,
                              rob: disp_rob};
                end
            end
        end
    end

    // Occupancy counter tracks fires rather than popcounting valid bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({disp_fire, iss_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
